// File: rtl/irq_arbiter_if.sv
// Interrupt arbiter bus: raw sources and core handshake in, request/cause/status out.
// master = core/platform side, slave = arbiter side.
interface irq_arbiter_if #(
   parameter int unsigned N_SRC = 16,
   parameter int unsigned ID_W  = $clog2(N_SRC)
);
   logic [N_SRC-1:0] src_i;
   logic [N_SRC-1:0] mask_i;
   logic             irq_taken_i;
   logic             irq_ret_i;
   logic             irq_req_o;
   logic [31:0]      irq_cause_o;
   logic [ID_W-1:0]  irq_id_o;
   logic [N_SRC-1:0] pending_o;
   logic             busy_o;

   modport master (
      output src_i, mask_i, irq_taken_i, irq_ret_i,
      input  irq_req_o, irq_cause_o, irq_id_o, pending_o, busy_o
   );

   modport slave (
      input  src_i, mask_i, irq_taken_i, irq_ret_i,
      output irq_req_o, irq_cause_o, irq_id_o, pending_o, busy_o
   );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched pending register feeding a single-request IDLE/REQ/SERVICE handshake.
// Fixed priority (lowest index) by default; define IRQ_ARB_ROUND_ROBIN_EN for round-robin.
module irq_arbiter #(
   parameter int unsigned N_SRC = 16,
   parameter int unsigned ID_W  = $clog2(N_SRC)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   irq_arbiter_if.slave bus
);
   localparam logic [31:0] CAUSE_BASE = 32'h1000_0010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SVC  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [N_SRC-1:0] r_src_q;
   logic [N_SRC-1:0] r_pend;
   logic [ID_W-1:0]  r_id;
   logic [31:0]      r_cause;
   logic             r_req;
   logic             r_busy;

   logic [N_SRC-1:0] w_edge;
   logic [N_SRC-1:0] w_cand;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_pend_nxt;
   logic [ID_W-1:0]  w_win;
   logic [ID_W-1:0]  w_id_nxt;
   logic [31:0]      w_cause_nxt;
   logic             w_req_nxt;
   logic             w_busy_nxt;
   logic             w_any;
   logic             w_take;
   logic             w_mask_cur;

   assign w_edge     = bus.src_i & ~r_src_q;
   assign w_cand     = r_pend & bus.mask_i;
   assign w_any      = |w_cand;
   assign w_take     = (r_state == S_REQ) && bus.irq_taken_i;
   assign w_mask_cur = bus.mask_i[r_id];

`ifdef IRQ_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_ptr_nxt;
   int unsigned     w_idx;
   logic            w_found;

   // Rotating search: first candidate at or after the slot following the last taken id.
   always_comb begin
      w_win   = '0;
      w_idx   = 0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         w_idx = (32'(r_ptr) + i) % N_SRC;
         if (!w_found && w_cand[ID_W'(w_idx)]) begin
            w_found = 1'b1;
            w_win   = ID_W'(w_idx);
         end
      end
   end

   assign w_ptr_nxt = (32'(r_id) == N_SRC - 1) ? '0 : r_id + ID_W'(1);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (w_take) begin
         r_ptr <= w_ptr_nxt;
      end
   end
`else
   // Fixed priority: scan downward so the lowest set index is the last one written.
   always_comb begin
      w_win = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_cand[ID_W'(i)]) begin
            w_win = ID_W'(i);
         end
      end
   end
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; taken has precedence over a same-cycle mask drop.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.irq_taken_i) begin
               w_state_nxt = S_SVC;
            end else if (!w_mask_cur) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SVC: begin
            if (bus.irq_ret_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; a fresh edge re-sets a bit cleared by taken.
   always_comb begin
      w_clr       = '0;
      w_pend_nxt  = r_pend;
      w_id_nxt    = r_id;
      w_cause_nxt = r_cause;
      w_req_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;

      if (w_take) begin
         w_clr = N_SRC'(1) << r_id;
      end
      w_pend_nxt = (r_pend & ~w_clr) | w_edge;

      if ((r_state == S_IDLE) && w_any) begin
         w_id_nxt = w_win;
      end
      w_cause_nxt = CAUSE_BASE + 32'(w_id_nxt);

      w_req_nxt  = (w_state_nxt == S_REQ);
      w_busy_nxt = (w_state_nxt == S_SVC);
   end

   // Registered outputs and edge-detect history.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_src_q <= '0;
         r_pend  <= '0;
         r_id    <= '0;
         r_cause <= CAUSE_BASE;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_src_q <= bus.src_i;
         r_pend  <= w_pend_nxt;
         r_id    <= w_id_nxt;
         r_cause <= w_cause_nxt;
         r_req   <= w_req_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign bus.irq_req_o   = r_req;
   assign bus.irq_cause_o = r_cause;
   assign bus.irq_id_o    = r_id;
   assign bus.pending_o   = r_pend;
   assign bus.busy_o      = r_busy;

endmodule
